fw_interface_regs: RTL and testbench

Wishbone classic slave that firmware on the SoC CPU writes to in order to post test reports, warnings, errors and message strings to the testbench. It sits directly upstream of the firmware-interface checker logic. It decodes bus writes into the checker's inputs: `report_reg`, `warning_reg` and `error_reg` values with single-cycle `new_*` strobes, plus `index`/`data`/`write_mem` byte writes into the checker's 64-entry string memory. It also keeps readable event counters and a string write pointer so firmware can check its own traffic.

---
 rtl/fw_interface_regs_if.sv | 24 ++
 rtl/fw_interface_regs.sv | 149 ++++++++++++++
 tb/tb_fw_interface_regs.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/fw_interface_regs_if.sv
// Wishbone classic bus bundle between the SoC CPU (master) and the firmware-interface register slave.
interface fw_interface_regs_if #(
   parameter int ADDR_WIDTH = 5
);
   logic [ADDR_WIDTH-1:0] wb_adr_i;
   logic [31:0]           wb_dat_i;
   logic [3:0]            wb_sel_i;
   logic                  wb_we_i;
   logic                  wb_cyc_i;
   logic                  wb_stb_i;
   logic [31:0]           wb_dat_o;
   logic                  wb_ack_o;
   logic                  wb_err_o;

   modport master (
      output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
      input  wb_dat_o, wb_ack_o, wb_err_o
   );

   modport slave (
      input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
      output wb_dat_o, wb_ack_o, wb_err_o
   );
endinterface

// File: rtl/fw_interface_regs.sv
// Firmware-facing Wishbone slave decoding report/warning/error/string writes into checker inputs.
// Latency 1 cycle (registered ack, idle cycle after); optional FW_INTERFACE_ERR_EN enables error responses.
module fw_interface_regs (
   input  logic                      wb_clk_i,
   input  logic                      wb_rst_i,
   fw_interface_regs_if.slave        wb,
   output logic [31:0]               report_reg,
   output logic [31:0]               warning_reg,
   output logic [31:0]               error_reg,
   output logic                      new_report,
   output logic                      new_warning,
   output logic                      new_error,
   output logic [5:0]                index,
   output logic [7:0]                data,
   output logic                      write_mem
);

   localparam logic [2:0] OFF_REPORT  = 3'd0;
   localparam logic [2:0] OFF_WARNING = 3'd1;
   localparam logic [2:0] OFF_ERROR   = 3'd2;
   localparam logic [2:0] OFF_STRING  = 3'd3;
   localparam logic [2:0] OFF_PTR     = 3'd4;
   localparam logic [2:0] OFF_COUNT   = 3'd5;

   logic [31:0] r_report, r_warning, r_error, r_rdata;
   logic        r_new_report, r_new_warning, r_new_error, r_write_mem, r_ack;
   logic [5:0]  r_index, r_ptr;
   logic [7:0]  r_data, r_rep_cnt, r_warn_cnt, r_err_cnt;

   logic [2:0]  w_off;
   logic        w_req, w_bad, w_acc, w_wr;
   logic [31:0] w_rd_mux;

   assign w_off = wb.wb_adr_i[4:2];

`ifdef FW_INTERFACE_ERR_EN
   logic r_err;
   assign w_req      = wb.wb_cyc_i & wb.wb_stb_i & ~r_ack & ~r_err;
   assign w_bad      = (w_off[2] & w_off[1]) | ((w_off == OFF_COUNT) & wb.wb_we_i);
   assign wb.wb_err_o = r_err;
`else
   assign w_req      = wb.wb_cyc_i & wb.wb_stb_i & ~r_ack;
   assign w_bad      = 1'b0;
   assign wb.wb_err_o = 1'b0;
`endif

   assign w_acc = w_req & ~w_bad;
   assign w_wr  = w_acc & wb.wb_we_i;

   function automatic logic [7:0] sat_inc(input logic [7:0] cnt);
      return (cnt == 8'hFF) ? cnt : cnt + 8'd1;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                         input logic [3:0] sel);
      logic [31:0] res;
      res = old_v;
      for (int b = 0; b < 4; b++) begin
         if (sel[b]) res[b*8 +: 8] = new_v[b*8 +: 8];
      end
      return res;
   endfunction

   // Read mux sees pre-write values; the write lands on the same edge as the registered read data.
   always_comb begin
      w_rd_mux = 32'h0;
      case (w_off)
         OFF_REPORT:  w_rd_mux = r_report;
         OFF_WARNING: w_rd_mux = r_warning;
         OFF_ERROR:   w_rd_mux = r_error;
         OFF_PTR:     w_rd_mux = {26'h0, r_ptr};
         OFF_COUNT:   w_rd_mux = {8'h0, r_err_cnt, r_warn_cnt, r_rep_cnt};
         default:     w_rd_mux = 32'h0;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_i) begin
         r_report      <= 32'h0;
         r_warning     <= 32'h0;
         r_error       <= 32'h0;
         r_rdata       <= 32'h0;
         r_new_report  <= 1'b0;
         r_new_warning <= 1'b0;
         r_new_error   <= 1'b0;
         r_write_mem   <= 1'b0;
         r_ack         <= 1'b0;
         r_index       <= 6'h0;
         r_data        <= 8'h0;
         r_ptr         <= 6'h0;
         r_rep_cnt     <= 8'h0;
         r_warn_cnt    <= 8'h0;
         r_err_cnt     <= 8'h0;
`ifdef FW_INTERFACE_ERR_EN
         r_err         <= 1'b0;
`endif
      end else begin
         r_ack         <= w_acc;
`ifdef FW_INTERFACE_ERR_EN
         r_err         <= w_req & w_bad;
`endif
         r_rdata       <= (w_acc & ~wb.wb_we_i) ? w_rd_mux : 32'h0;
         r_new_report  <= w_wr & (w_off == OFF_REPORT);
         r_new_warning <= w_wr & (w_off == OFF_WARNING);
         r_new_error   <= w_wr & (w_off == OFF_ERROR);
         r_write_mem   <= w_wr & (w_off == OFF_STRING) & wb.wb_sel_i[0];
         if (w_wr) begin
            case (w_off)
               OFF_REPORT: begin
                  r_report  <= merge(r_report, wb.wb_dat_i, wb.wb_sel_i);
                  r_rep_cnt <= sat_inc(r_rep_cnt);
               end
               OFF_WARNING: begin
                  r_warning  <= merge(r_warning, wb.wb_dat_i, wb.wb_sel_i);
                  r_warn_cnt <= sat_inc(r_warn_cnt);
               end
               OFF_ERROR: begin
                  r_error   <= merge(r_error, wb.wb_dat_i, wb.wb_sel_i);
                  r_err_cnt <= sat_inc(r_err_cnt);
               end
               OFF_STRING: begin
                  if (wb.wb_sel_i[0]) begin
                     r_data  <= wb.wb_dat_i[7:0];
                     r_index <= r_ptr;
                     r_ptr   <= r_ptr + 6'd1;
                  end
               end
               OFF_PTR: begin
                  if (wb.wb_sel_i[0] & wb.wb_dat_i[0]) r_ptr <= 6'h0;
               end
               default: ;
            endcase
         end
      end
   end

   assign wb.wb_dat_o = r_rdata;
   assign wb.wb_ack_o = r_ack;
   assign report_reg  = r_report;
   assign warning_reg = r_warning;
   assign error_reg   = r_error;
   assign new_report  = r_new_report;
   assign new_warning = r_new_warning;
   assign new_error   = r_new_error;
   assign index       = r_index;
   assign data        = r_data;
   assign write_mem   = r_write_mem;

endmodule

// File: tb/tb_fw_interface_regs.sv
// Directed bench for fw_interface_regs with read-data and string-write scoreboards.
module tb_fw_interface_regs;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] report_reg, warning_reg, error_reg;
   logic        new_report, new_warning, new_error, write_mem;
   logic [5:0]  index;
   logic [7:0]  data;

   int          n_assert = 0;
   int          n_fail   = 0;
   int          n_err_pulse = 0;
   logic [31:0] q_rd[$];
   logic [13:0] q_str[$];

   always #5 clk = ~clk;

   fw_interface_regs_if #(.ADDR_WIDTH(5)) bus ();

   fw_interface_regs dut (
      .wb_clk_i    (clk),
      .wb_rst_i    (rst_n),
      .wb          (bus),
      .report_reg  (report_reg),
      .warning_reg (warning_reg),
      .error_reg   (error_reg),
      .new_report  (new_report),
      .new_warning (new_warning),
      .new_error   (new_error),
      .index       (index),
      .data        (data),
      .write_mem   (write_mem)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // String scoreboard and strobe/ack alignment, sampled mid-cycle.
   always @(negedge clk) begin : mon
      logic [13:0] e;
      if (write_mem === 1'b1) begin
         if (q_str.size() == 0) begin
            chk("write_mem_unexpected", 32'h1, 32'h0);
         end else begin
            e = q_str.pop_front();
            chk("str_index", {26'h0, index}, {26'h0, e[13:8]});
            chk("str_data", {24'h0, data}, {24'h0, e[7:0]});
         end
      end
      if (new_error === 1'b1) n_err_pulse++;
      if ((new_report | new_warning | new_error | write_mem) === 1'b1)
         chk("strobe_with_ack", {31'h0, bus.wb_ack_o}, 32'h1);
   end

   task automatic xfer(input logic we, input logic [2:0] off, input logic [31:0] d,
                       input logic [3:0] sel, input logic exp_err);
      logic        got;
      logic [31:0] exp_d;
      logic [2:0]  exp_strb;
      @(posedge clk); #1;
      bus.wb_cyc_i = 1'b1;
      bus.wb_stb_i = 1'b1;
      bus.wb_we_i  = we;
      bus.wb_adr_i = {off, 2'b00};
      bus.wb_dat_i = d;
      bus.wb_sel_i = sel;
      got = 1'b0;
      for (int c = 0; c < 8 && !got; c++) begin
         @(posedge clk); #1;
         if (bus.wb_ack_o === 1'b1 || bus.wb_err_o === 1'b1) got = 1'b1;
      end
      exp_strb = exp_err ? 3'b000 : {we && off == 3'd0, we && off == 3'd1, we && off == 3'd2};
      if (!got) begin
         chk("xfer_timeout", 32'h0, 32'h1);
         if (!we) void'(q_rd.pop_front());
      end else begin
         chk("resp_err", {31'h0, bus.wb_err_o}, {31'h0, exp_err});
         chk("resp_ack", {31'h0, bus.wb_ack_o}, {31'h0, !exp_err});
         if (!we) begin
            exp_d = q_rd.pop_front();
            chk("rdata", bus.wb_dat_o, exp_d);
         end
         chk("strobes", {29'h0, new_report, new_warning, new_error}, {29'h0, exp_strb});
      end
      bus.wb_cyc_i = 1'b0;
      bus.wb_stb_i = 1'b0;
      bus.wb_we_i  = 1'b0;
      @(posedge clk); #1;
      chk("resp_one_cycle", {30'h0, bus.wb_ack_o, bus.wb_err_o}, 32'h0);
      chk("strobes_one_cycle", {29'h0, new_report, new_warning, new_error}, 32'h0);
   endtask

   task automatic rd(input logic [2:0] off, input logic [31:0] exp, input logic exp_err);
      q_rd.push_back(exp);
      xfer(1'b0, off, 32'h0, 4'hF, exp_err);
   endtask

   task automatic wr(input logic [2:0] off, input logic [31:0] d, input logic [3:0] sel,
                     input logic exp_err);
      xfer(1'b1, off, d, sel, exp_err);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.wb_cyc_i = 1'b0;
      bus.wb_stb_i = 1'b0;
      bus.wb_we_i  = 1'b0;
      bus.wb_adr_i = '0;
      bus.wb_dat_i = '0;
      bus.wb_sel_i = '0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      chk("rst_report", report_reg, 32'h0);
      chk("rst_warning", warning_reg, 32'h0);
      chk("rst_error", error_reg, 32'h0);
      chk("rst_strobes", {28'h0, new_report, new_warning, new_error, write_mem}, 32'h0);
      chk("rst_index_data", {18'h0, index, data}, 32'h0);
      chk("rst_bus", {bus.wb_dat_o[29:0], bus.wb_ack_o, bus.wb_err_o}, 32'h0);
      rd(3'd5, 32'h0, 1'b0);
      rd(3'd4, 32'h0, 1'b0);

      wr(3'd0, 32'hDEAD_BEEF, 4'hF, 1'b0);
      chk("report_full", report_reg, 32'hDEAD_BEEF);
      rd(3'd0, 32'hDEAD_BEEF, 1'b0);
      rd(3'd5, 32'h0000_0001, 1'b0);

      wr(3'd1, 32'h1122_3344, 4'h3, 1'b0);
      chk("warning_partial", warning_reg, 32'h0000_3344);
      rd(3'd1, 32'h0000_3344, 1'b0);

      wr(3'd0, 32'h1234_5678, 4'h0, 1'b0);
      chk("report_sel0", report_reg, 32'hDEAD_BEEF);
      wr(3'd0, 32'h0000_AA00, 4'h2, 1'b0);
      chk("report_lane1", report_reg, 32'hDEAD_AAEF);
      rd(3'd5, 32'h0000_0103, 1'b0);

      for (int i = 0; i < 65; i++) begin
         q_str.push_back({6'(i % 64), 8'(8'h41 + i)});
         wr(3'd3, 32'h41 + i, 4'h1, 1'b0);
      end
      chk("str_all_seen", q_str.size(), 32'h0);
      rd(3'd4, 32'h1, 1'b0);
      wr(3'd4, 32'h2, 4'hF, 1'b0);
      rd(3'd4, 32'h1, 1'b0);
      wr(3'd4, 32'h1, 4'hE, 1'b0);
      rd(3'd4, 32'h1, 1'b0);
      wr(3'd4, 32'h1, 4'h1, 1'b0);
      rd(3'd4, 32'h0, 1'b0);
      wr(3'd3, 32'h55, 4'hE, 1'b0);
      rd(3'd4, 32'h0, 1'b0);
      rd(3'd3, 32'h0, 1'b0);

      n_err_pulse = 0;
      for (int i = 0; i < 300; i++) wr(3'd2, i, 4'hF, 1'b0);
      chk("error_last", error_reg, 32'd299);
      chk("error_pulses", n_err_pulse, 32'd300);
      rd(3'd5, 32'h00FF_0103, 1'b0);

      // Held strobe: ack pattern 1,0,1,0 with data on each ack cycle.
      @(posedge clk); #1;
      bus.wb_cyc_i = 1'b1;
      bus.wb_stb_i = 1'b1;
      bus.wb_we_i  = 1'b0;
      bus.wb_adr_i = 5'h0;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         chk("held_ack", {31'h0, bus.wb_ack_o}, {31'h0, c[0] == 1'b0});
         chk("held_dat", bus.wb_dat_o, (c[0] == 1'b0) ? 32'hDEAD_AAEF : 32'h0);
      end
      bus.wb_cyc_i = 1'b0;
      bus.wb_stb_i = 1'b0;
      @(posedge clk); #1;

`ifdef FW_INTERFACE_ERR_EN
      rd(3'd6, 32'h0, 1'b1);
      wr(3'd7, 32'hFFFF_FFFF, 4'hF, 1'b1);
      wr(3'd5, 32'hFFFF_FFFF, 4'hF, 1'b1);
`else
      rd(3'd6, 32'h0, 1'b0);
      wr(3'd6, 32'hFFFF_FFFF, 4'hF, 1'b0);
      wr(3'd5, 32'hFFFF_FFFF, 4'hF, 1'b0);
      rd(3'd7, 32'h0, 1'b0);
`endif
      rd(3'd5, 32'h00FF_0103, 1'b0);
      rd(3'd0, 32'hDEAD_AAEF, 1'b0);

      // Reset lands on the edge that would have accepted a string write.
      @(posedge clk); #1;
      bus.wb_cyc_i = 1'b1;
      bus.wb_stb_i = 1'b1;
      bus.wb_we_i  = 1'b1;
      bus.wb_adr_i = {3'd3, 2'b00};
      bus.wb_dat_i = 32'h5A;
      bus.wb_sel_i = 4'hF;
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("rst_mid_ack", {30'h0, bus.wb_ack_o, bus.wb_err_o}, 32'h0);
      chk("rst_mid_wmem", {31'h0, write_mem}, 32'h0);
      bus.wb_cyc_i = 1'b0;
      bus.wb_stb_i = 1'b0;
      bus.wb_we_i  = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      rd(3'd4, 32'h0, 1'b0);
      rd(3'd5, 32'h0, 1'b0);
      chk("rst_mid_report", report_reg, 32'h0);
      chk("rst_mid_idx", {26'h0, index}, 32'h0);
      repeat (3) @(posedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
